simple_st0_mem_fifo_ctrl: RTL
=============================

# simple_st0_mem_fifo_ctrl

Streaming FIFO controller sitting directly upstream and downstream of the simple_st0 64×32 memory wrapper. It accepts a valid/ready word stream, writes it into the memory as a circular buffer, and reads words back out in order onto a valid/ready output stream. A two-entry output buffer absorbs the memory's one-cycle read latency, so sustained throughput is one word per cycle.

## Interface
- WIDTH, 32, data word width; must match the memory wrapper
- ADDR_W, 6, memory address width; depth = 2^ADDR_W = 64
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream word valid
- in_data  input  WIDTH  upstream word
- in_ready  output  1  controller accepts in_data this cycle
- out_valid  output  1  output word valid
- out_data  output  WIDTH  output word
- out_ready  input  1  downstream accepts out_data
- mem_wr_en  output  1  memory write strobe
- mem_wr_addr  output  ADDR_W  memory write address
- mem_wr_data  output  WIDTH  memory write data
- mem_rd_en  output  1  memory read strobe
- mem_rd_addr  output  ADDR_W  memory read address
- mem_rd_data  input  WIDTH  memory read data; valid the cycle after mem_rd_en
- level  output  ADDR_W+1  words held: memory count + reads in flight + output buffer entries

## Operation
- State: wr_ptr and rd_ptr, each ADDR_W bits, wrap modulo 2^ADDR_W. mem_cnt is 0..64. rd_pend flag. 2-entry output buffer obuf[0..1] with obuf_cnt 0..2.
- Write side: in_ready = reset high and mem_cnt < 64, using registered mem_cnt. On in_valid & in_ready: mem_wr_en=1, mem_wr_addr=wr_ptr, mem_wr_data=in_data, all combinational. wr_ptr increments on the next edge.
- Read issue: mem_rd_en = mem_cnt > 0 and (obuf_cnt + rd_pend − out_fire) < 2, where out_fire = out_valid & out_ready. mem_rd_addr = rd_ptr. On issue: rd_ptr++ and rd_pend is set for the next cycle.
- mem_cnt next = mem_cnt + wr_fire − rd_issue; simultaneous write and read leaves it unchanged.
- Read return: when rd_pend=1, mem_rd_data is written into obuf at the tail. obuf is ordered: obuf[0] is the head.
- Output: out_valid = obuf_cnt > 0; out_data = obuf[0]. On out_fire, obuf shifts. A simultaneous return and pop is legal and keeps order.
- There is no read/write address collision: writes are blocked when mem_cnt = 64, so wr_ptr never equals an unread rd_ptr slot.
- Full: in_ready=0 while mem_cnt=64. Total capacity is 66 words: 64 in memory plus 2 in obuf.
- Empty: mem_rd_en=0 while mem_cnt=0. out_valid drops once obuf drains.
- Wrap: pointer 63 → 0 with no gap or bubble.
- Upstream contract: in_data must be held stable while in_valid & !in_ready. The controller holds out_data stable while out_valid & !out_ready.

## Timing
- Reset (reset low, asynchronous): wr_ptr=rd_ptr=0, mem_cnt=0, rd_pend=0, obuf_cnt=0, obuf data=0.
- Outputs during reset: in_ready=0, out_valid=0, out_data=0, mem_wr_en=0, mem_rd_en=0, both addresses 0, level=0.
- Reset mid-operation discards all contents immediately. The first in_ready=1 is the first cycle after reset deasserts.
- Latency: input fire at cycle N → write at N → mem_cnt>0 at N+1 → mem_rd_en at N+1 → obuf loaded at edge N+2 → out_valid=1 at cycle N+3.
- Throughput: with out_ready held high and input streaming, one word per cycle in and out after the 3-cycle fill.
- Backpressure: out_ready low stops reads once obuf_cnt + rd_pend = 2. No return data is ever dropped.
- level is registered and updates the cycle after the causing event.

## Test plan
- Single word: reset, push 0xDEADBEEF at cycle 5 → mem_wr_addr=0 at cycle 5; out_valid=1 with out_data=0xDEADBEEF at cycle 8; level returns to 0 after the pop.
- Fill to full: out_ready=0, push 0..69 → in_ready falls after 66 accepts and level=66. Then out_ready=1 → outputs 0..65 in order, with no gaps after the first.
- Streaming wrap: out_ready=1, push 200 incrementing words back-to-back → output identical sequence at 1 word/cycle; pointers wrap 63→0 three times.
- Random backpressure: random in_valid and out_ready at 50% each, 2000 words → scoreboard order exact, no loss or duplication; level never exceeds 66.
- Simultaneous push/pop at mem_cnt=64: pop one word → in_ready reasserts next cycle; a push in that cycle writes to the freed slot with no corruption.
- Reset mid-stream: reset low for 1 cycle with 20 words held → out_valid=0 immediately, level=0; subsequent push of 0x1 emerges as the first output.

Source files
------------

// File: rtl/simple_st0_mem_fifo_ctrl.sv
// Streaming FIFO controller around the simple_st0 64x32 memory wrapper.
// Input words are written into the memory as a circular buffer; reads are
// issued ahead into a two-entry output buffer.
// The output buffer hides the one-cycle memory read latency.
// That gives one word per cycle on both sides once the pipe has filled.
module simple_st0_mem_fifo_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic              rd_pend;
  logic [WIDTH-1:0]  obuf0;
  logic [WIDTH-1:0]  obuf1;
  logic [1:0]        obuf_cnt;
  logic [ADDR_W:0]   level_q;

  logic       wr_fire;
  logic       rd_issue;
  logic       out_fire;
  logic [2:0] occ;
  logic [2:0] occ_limit;
  logic [1:0] tail;

  // Handshakes and memory strobes; in_ready is held low while in reset so
  // nothing is accepted before the state registers are released.
  always_comb begin
    in_ready    = reset && (mem_cnt != FULL_CNT);
    wr_fire     = in_valid && in_ready;
    out_valid   = (obuf_cnt != 2'd0);
    out_data    = obuf0;
    out_fire    = out_valid && out_ready;
    // A read may issue only if its data has a free obuf slot when it returns,
    // counting the slot freed by a pop happening this cycle.
    occ         = {1'b0, obuf_cnt} + {2'b00, rd_pend};
    occ_limit   = 3'd2 + {2'b00, out_fire};
    rd_issue    = (mem_cnt != '0) && (occ < occ_limit);
    tail        = obuf_cnt - {1'b0, out_fire};
    mem_wr_en   = wr_fire;
    mem_wr_addr = wr_ptr;
    mem_wr_data = in_data;
    mem_rd_en   = rd_issue;
    mem_rd_addr = rd_ptr;
    level       = level_q;
  end

  // Pointers, memory occupancy and the in-flight read flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (wr_fire)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      rd_pend <= rd_issue;
      case ({wr_fire, rd_issue})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  // Output buffer: pop shifts toward the head, returning read data lands at
  // the tail as seen after this cycle's pop, so order survives a same-cycle
  // pop and return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      obuf0    <= '0;
      obuf1    <= '0;
      obuf_cnt <= 2'd0;
    end else begin
      if (out_fire) obuf0 <= obuf1;
      if (rd_pend) begin
        if (tail == 2'd0) obuf0 <= mem_rd_data;
        else              obuf1 <= mem_rd_data;
      end
      obuf_cnt <= obuf_cnt + {1'b0, rd_pend} - {1'b0, out_fire};
    end
  end

  // Total words held; the move from memory to obuf leaves this unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
    end else begin
      case ({wr_fire, out_fire})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
